fetch_buffer: RTL and testbench

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/fetch_buffer_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/fetch_fifo_checker.sv | 21 ++
 rtl/fetch_buffer.sv | 77 +++++++
 tb/tb_fetch_buffer.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_buffer_pkg.sv
// Shared definitions for the fetch buffer: word type, reset PC,
// default FIFO depth and the queued entry layout.
package fetch_buffer_pkg;

  typedef logic [31:0] int_t;

  localparam int_t PC_INIT             = 32'h0000_3000;
  localparam int   FETCH_DEPTH_DEFAULT = 4;

  typedef struct packed {
    int_t pc;
    int_t instruction;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular queue of fetched {pc, instruction} entries with
// first-word fall-through head and a single-cycle clear.
module fetch_fifo
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH_DEFAULT,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output fetch_entry_t head_entry,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem_r [DEPTH];
  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  // Clear wins over both push and pop; popping an empty queue is a no-op.
  assign do_push_s = push && !clear && !reset;
  assign do_pop_s  = pop && (count_r != {CW{1'b0}}) && !clear;

  assign head_entry = mem_r[head_r];
  assign count      = count_r;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (do_push_s) tail_r <= tail_r + PW'(1'b1);
      if (do_pop_s)  head_r <= head_r + PW'(1'b1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage is deliberately left unreset.
  always_ff @(posedge clock) begin
    if (do_push_s) mem_r[tail_r] <= push_entry;
  end

  fetch_fifo_checker #(.DEPTH(DEPTH), .CW(CW)) u_checker (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .clear (clear),
    .count (count_r)
  );

endmodule

// File: rtl/fetch_fifo_checker.sv
// Protocol checks for fetch_fifo: the issue throttle must never let a
// response land on a full queue.
module fetch_fifo_checker #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          clock,
  input logic          reset,
  input logic          push,
  input logic          clear,
  input logic [CW-1:0] count
);

  localparam logic [CW-1:0] DEPTH_L = CW'(DEPTH);

  // A surviving push must always find a free slot.
  a_no_push_when_full: assert property (
    @(posedge clock) disable iff (reset) (push && !clear) |-> (count != DEPTH_L)
  );

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch front end: issues imem reads from the PC, tags the
// one-cycle-late response and queues it for decode, throttling the PC.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int FETCH_DEPTH = FETCH_DEPTH_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  int_t pcValue,
  output logic fetchStall,
  input  logic flush,
  output logic imemReadEnable,
  output int_t imemAddr,
  input  int_t imemData,
  output logic decodeValid,
  output int_t decodePC,
  output int_t decodeInstruction,
  input  logic decodeReady
);

  localparam int CW = $clog2(FETCH_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_L = (CW + 1)'(FETCH_DEPTH);

  logic          primed_r;
  logic          in_flight_r;
  int_t          issue_pc_r;
  logic [CW-1:0] count_s;
  logic [CW:0]   occupancy_s;
  logic          push_s;
  logic          pop_s;
  fetch_entry_t  head_s;
  fetch_entry_t  push_entry_s;

  // An outstanding read reserves its slot; pops this cycle are not credited.
  assign occupancy_s = {1'b0, count_s} + {{CW{1'b0}}, in_flight_r};

  assign fetchStall     = reset || (!flush && (!primed_r || (occupancy_s >= DEPTH_L)));
  assign imemReadEnable = !reset && primed_r && !fetchStall && !flush;
  assign imemAddr       = pcValue;

  assign decodeValid       = !reset && (count_s != {CW{1'b0}}) && !flush;
  assign decodePC          = head_s.pc;
  assign decodeInstruction = head_s.instruction;

  assign push_s       = in_flight_r && !flush;
  assign pop_s        = decodeValid && decodeReady;
  assign push_entry_s = '{pc: issue_pc_r, instruction: imemData};

  // Primed skips the first post-reset cycle; in-flight tags next cycle's imemData.
  always_ff @(posedge clock) begin
    if (reset) begin
      primed_r    <= 1'b0;
      in_flight_r <= 1'b0;
    end else begin
      primed_r    <= 1'b1;
      in_flight_r <= imemReadEnable;
    end
  end

  // Remember the address of the outstanding read so it can be queued with its data.
  always_ff @(posedge clock) begin
    if (imemReadEnable) issue_pc_r <= pcValue;
  end

  fetch_fifo #(.DEPTH(FETCH_DEPTH)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .clear      (flush),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .head_entry (head_s),
    .count      (count_s)
  );

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed and randomized bench for fetch_buffer with a PC model and an
// instruction memory returning address ^ 0xA5A5A5A5 one cycle after a read.
module tb_fetch_buffer;
  import fetch_buffer_pkg::*;

  localparam int_t KEY = 32'hA5A5_A5A5;

  logic clock;
  logic reset;
  logic flush;
  logic decodeReady;
  logic fetchStall;
  logic imemReadEnable;
  logic decodeValid;
  int_t pcValue;
  int_t imemAddr;
  int_t imemData;
  int_t decodePC;
  int_t decodeInstruction;
  int_t target;

  logic s_re, s_stall, s_valid;
  int_t s_addr, s_pc, s_ins;

  int n_checks = 0;
  int n_fail   = 0;
  int n_dec    = 0;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        re;
    logic [31:0] addr;
    logic        stall;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs [18];

  fetch_buffer #(.FETCH_DEPTH(4)) dut (
    .clock             (clock),
    .reset             (reset),
    .pcValue           (pcValue),
    .fetchStall        (fetchStall),
    .flush             (flush),
    .imemReadEnable    (imemReadEnable),
    .imemAddr          (imemAddr),
    .imemData          (imemData),
    .decodeValid       (decodeValid),
    .decodePC          (decodePC),
    .decodeInstruction (decodeInstruction),
    .decodeReady       (decodeReady)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply inputs for one cycle and sample outputs on the falling edge.
  task automatic step(input logic rst, input logic fl, input int_t tgt, input logic rdy);
    reset       = rst;
    flush       = fl;
    target      = tgt;
    decodeReady = rdy;
    @(negedge clock);
    s_re    = imemReadEnable;
    s_addr  = imemAddr;
    s_stall = fetchStall;
    s_valid = decodeValid;
    s_pc    = decodePC;
    s_ins   = decodeInstruction;
  endtask

  // Cross the rising edge and update the PC and memory models.
  task automatic advance();
    @(posedge clock);
    #1;
    imemData = s_re ? (s_addr ^ KEY) : 32'hDEAD_BEEF;
    if (reset)         pcValue = PC_INIT;
    else if (flush)    pcValue = target;
    else if (!s_stall) pcValue = pcValue + 32'd4;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int k = 0; k < n; k++) begin
      step(1'b0, 1'b0, 32'h0, rdy);
      advance();
    end
  endtask

  task automatic expect_cycle(input string tag, input logic re, input int_t addr,
                              input logic stall, input logic valid, input int_t pc);
    check_bit({tag, ".re"}, s_re, re);
    check_word({tag, ".addr"}, s_addr, addr);
    check_bit({tag, ".stall"}, s_stall, stall);
    check_bit({tag, ".valid"}, s_valid, valid);
    if (valid) begin
      check_word({tag, ".pc"}, s_pc, pc);
      check_word({tag, ".ins"}, s_ins, pc ^ KEY);
    end
  endtask

  initial begin
    int_t exp_next;
    logic rdy_r, fl_r;
    int_t tgt_r;

    reset = 1'b1; flush = 1'b0; decodeReady = 1'b0;
    pcValue = PC_INIT; imemData = 32'hDEAD_BEEF; target = 32'h0;

    // Streaming from reset release, then fill-to-stall with decode held off.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h3000, 1'b1, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h3000, 1'b1, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h3000, 1'b1, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 32'h3000, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 32'h3004, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 32'h3008, 1'b0, 1'b1, 32'h3000};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 32'h300C, 1'b0, 1'b1, 32'h3004};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 32'h3010, 1'b0, 1'b1, 32'h3008};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'h3014, 1'b1, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h3000, 1'b1, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h3000, 1'b0, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h3004, 1'b0, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 32'h3008, 1'b0, 1'b1, 32'h3000};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 32'h300C, 1'b0, 1'b1, 32'h3000};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h3010, 1'b1, 1'b1, 32'h3000};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 32'h3010, 1'b1, 1'b1, 32'h3000};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 32'h3010, 1'b0, 1'b1, 32'h3004};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 32'h3014, 1'b1, 1'b1, 32'h3004};

    for (int i = 0; i < 18; i++) begin
      step(vecs[i].rst, 1'b0, 32'h0, vecs[i].rdy);
      expect_cycle($sformatf("vec%0d", i), vecs[i].re, vecs[i].addr,
                   vecs[i].stall, vecs[i].valid, vecs[i].pc);
      advance();
    end

    // Queue is full here; a flush must override the stall immediately.
    step(1'b0, 1'b1, 32'h5000, 1'b1);
    expect_cycle("flush_full", 1'b0, 32'h3014, 1'b0, 1'b0, 32'h0);
    advance();
    step(1'b0, 1'b0, 32'h0, 1'b1);
    expect_cycle("flush_full+1", 1'b1, 32'h5000, 1'b0, 1'b0, 32'h0);
    advance();
    step(1'b0, 1'b0, 32'h0, 1'b1);
    expect_cycle("flush_full+2", 1'b1, 32'h5004, 1'b0, 1'b0, 32'h0);
    advance();
    step(1'b0, 1'b0, 32'h0, 1'b1);
    expect_cycle("flush_full+3", 1'b1, 32'h5008, 1'b0, 1'b1, 32'h5000);
    advance();

    // Flush with three entries queued and one read outstanding.
    step(1'b1, 1'b0, 32'h0, 1'b0);
    advance();
    idle(5, 1'b0);
    step(1'b0, 1'b1, 32'h4000, 1'b1);
    expect_cycle("flush_q3", 1'b0, 32'h3010, 1'b0, 1'b0, 32'h0);
    advance();
    step(1'b0, 1'b0, 32'h0, 1'b1);
    expect_cycle("flush_q3+1", 1'b1, 32'h4000, 1'b0, 1'b0, 32'h0);
    advance();
    step(1'b0, 1'b0, 32'h0, 1'b1);
    expect_cycle("flush_q3+2", 1'b1, 32'h4004, 1'b0, 1'b0, 32'h0);
    advance();
    step(1'b0, 1'b0, 32'h0, 1'b1);
    expect_cycle("flush_q3+3", 1'b1, 32'h4008, 1'b0, 1'b1, 32'h4000);
    advance();

    // Reset with two entries queued and one read outstanding.
    step(1'b1, 1'b0, 32'h0, 1'b0);
    advance();
    idle(4, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    expect_cycle("rst_mid", 1'b0, 32'h300C, 1'b1, 1'b0, 32'h0);
    advance();
    step(1'b0, 1'b0, 32'h0, 1'b1);
    expect_cycle("rst_mid+1", 1'b0, 32'h3000, 1'b1, 1'b0, 32'h0);
    advance();
    step(1'b0, 1'b0, 32'h0, 1'b1);
    expect_cycle("rst_mid+2", 1'b1, 32'h3000, 1'b0, 1'b0, 32'h0);
    advance();
    step(1'b0, 1'b0, 32'h0, 1'b1);
    expect_cycle("rst_mid+3", 1'b1, 32'h3004, 1'b0, 1'b0, 32'h0);
    advance();
    step(1'b0, 1'b0, 32'h0, 1'b1);
    expect_cycle("rst_mid+4", 1'b1, 32'h3008, 1'b0, 1'b1, 32'h3000);
    advance();

    // Random back-pressure and redirects: decode must see an unbroken +4 stream.
    step(1'b1, 1'b0, 32'h0, 1'b0);
    advance();
    exp_next = PC_INIT;
    for (int c = 0; c < 2000; c++) begin
      rdy_r = 1'($urandom_range(0, 1));
      fl_r  = ($urandom_range(0, 99) < 5);
      tgt_r = 32'h0001_0000 + 32'($urandom_range(0, 4095)) * 32'd4;
      step(1'b0, fl_r, tgt_r, rdy_r);
      check_word("rnd.addr", s_addr, pcValue);
      if (fl_r) begin
        check_bit("rnd.flush_stall", s_stall, 1'b0);
        check_bit("rnd.flush_valid", s_valid, 1'b0);
        exp_next = tgt_r;
      end else if (s_valid && rdy_r) begin
        check_word("rnd.pc", s_pc, exp_next);
        check_word("rnd.ins", s_ins, exp_next ^ KEY);
        exp_next = exp_next + 32'd4;
        n_dec++;
      end
      advance();
    end
    n_checks++;
    if (n_dec < 400) begin
      n_fail++;
      $display("FAIL rnd.throughput: got %0d decodes expected at least 400", n_dec);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
